// File: rtl/ser_pkg.sv
// ser_pkg: definitions shared by the serial receive path.
//   - rx_state_t : receive FSM state encoding
//   - SCNT_MID   : oversample count at the middle of the start bit
//   - SCNT_BIT   : oversample count at which each later bit is sampled
//   - DATA_BITS  : data bits per frame
package ser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } rx_state_t;

    localparam logic [3:0] SCNT_MID  = 4'd7;
    localparam logic [3:0] SCNT_BIT  = 4'd15;
    localparam int         DATA_BITS = 8;

endpackage

// File: rtl/ser_fifo.sv
// ser_fifo: synchronous first-word-fall-through FIFO, depth 2^FIFO_AW.
// Ports:
//   clk        in   sole clock
//   reset      in   synchronous active-high reset (empties the FIFO)
//   i_push     in   write i_wdata (dropped when full unless popping too)
//   i_wdata    in   DW  write data
//   i_pop      in   advance the head (ignored while empty)
//   o_rdata    out  DW  head entry, 0 while empty
//   o_empty    out  FIFO empty
//   o_full     out  FIFO holds 2^FIFO_AW entries
//   o_overrun  out  single-cycle pulse: a push was dropped
module ser_fifo #(
    parameter int FIFO_AW = 3,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_pop,
    output logic [DW-1:0] o_rdata,
    output logic          o_empty,
    output logic          o_full,
    output logic          o_overrun
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [DW-1:0]    r_mem [DEPTH];
    logic [FIFO_AW:0] r_wptr;
    logic [FIFO_AW:0] r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indexes match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                     (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);

    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_overrun = i_push && !w_do_push;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[FIFO_AW-1:0]] <= i_wdata;
    end

    // Fall-through head; forced to 0 while empty so stale data never shows.
    assign o_rdata = o_empty ? '0 : r_mem[r_rptr[FIFO_AW-1:0]];

endmodule

// File: rtl/ser_rx_fifo.sv
// ser_rx_fifo: 16x oversampling UART receiver (8 data bits, LSB first,
// 1 stop bit) feeding a first-word-fall-through byte FIFO.
// Optional feature macro: SER_RX_PARITY_EN adds an even-parity bit between
// the data and stop bits; without it parity_err is tied 0.
// Ports:
//   clk          in   sole clock
//   reset        in   synchronous active-high reset
//   rx           in   asynchronous serial line, idle high
//   rd_en        in   pop the head byte (ignored while empty)
//   err_clr      in   clear sticky error flags (a coincident set wins)
//   rd_data      out  8  FIFO head, valid while rd_valid
//   rd_valid     out  FIFO not empty
//   full         out  FIFO full
//   busy         out  receiver FSM not idle
//   frame_err    out  sticky: stop bit sampled low
//   overrun_err  out  sticky: byte dropped because FIFO was full
//   parity_err   out  sticky: parity mismatch
import ser_pkg::*;

module ser_rx_fifo #(
    parameter int BAUD_DIV = 8,
    parameter int FIFO_AW  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       full,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err
);

    localparam int DIV_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic             r_rx_meta;
    logic             r_rxs;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;

    rx_state_t        r_state, w_state_next;
    logic [3:0]       r_scnt, w_scnt_next;
    logic [2:0]       r_bitcnt, w_bitcnt_next;
    logic [7:0]       r_shift, w_shift_next;
    logic             w_push;
    logic             w_frame_set;
    logic             w_overrun;
    logic             w_empty;
    logic             r_frame_err;
    logic             r_overrun_err;
`ifdef SER_RX_PARITY_EN
    logic             w_par_set;
    logic             r_parity_err;
`endif

    // Two-flop synchronizer, reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    // Free-running oversample tick divider.
    assign w_tick = (r_div == DIV_W'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || w_tick) r_div <= '0;
        else                 r_div <= r_div + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_scnt   <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_scnt   <= w_scnt_next;
            r_bitcnt <= w_bitcnt_next;
            r_shift  <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_scnt_next   = w_tick ? r_scnt + 4'd1 : r_scnt;
        w_bitcnt_next = r_bitcnt;
        w_shift_next  = r_shift;
        w_push        = 1'b0;
        w_frame_set   = 1'b0;
`ifdef SER_RX_PARITY_EN
        w_par_set     = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_tick && !r_rxs) begin
                    w_scnt_next  = '0;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                // Re-check the line at the start-bit midpoint; realigning
                // scnt here makes every later sample land mid-bit.
                if (w_tick && r_scnt == SCNT_MID) begin
                    if (!r_rxs) begin
                        w_scnt_next   = '0;
                        w_bitcnt_next = '0;
                        w_state_next  = ST_DATA;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick && r_scnt == SCNT_BIT) begin
                    w_shift_next  = {r_rxs, r_shift[7:1]};
                    w_bitcnt_next = r_bitcnt + 3'd1;
                    if (r_bitcnt == LAST_BIT) begin
`ifdef SER_RX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef SER_RX_PARITY_EN
            ST_PARITY: begin
                if (w_tick && r_scnt == SCNT_BIT) begin
                    w_par_set    = (r_rxs != ^r_shift);
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick && r_scnt == SCNT_BIT) begin
                    if (r_rxs) begin
                        w_push       = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_frame_set  = 1'b1;
                        w_state_next = ST_WAIT_HI;
                    end
                end
            end
            ST_WAIT_HI: begin
                // Hold off until the line returns high so a break does not
                // look like a stream of new start bits.
                if (w_tick && r_rxs) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    ser_fifo #(
        .FIFO_AW (FIFO_AW),
        .DW      (8)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_wdata   (r_shift),
        .i_pop     (rd_en),
        .o_rdata   (rd_data),
        .o_empty   (w_empty),
        .o_full    (full),
        .o_overrun (w_overrun)
    );

    // Sticky flags: a set event takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            if (w_frame_set)  r_frame_err <= 1'b1;
            else if (err_clr) r_frame_err <= 1'b0;
            if (w_overrun)    r_overrun_err <= 1'b1;
            else if (err_clr) r_overrun_err <= 1'b0;
        end
    end

`ifdef SER_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset)          r_parity_err <= 1'b0;
        else if (w_par_set) r_parity_err <= 1'b1;
        else if (err_clr)   r_parity_err <= 1'b0;
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign rd_valid    = !w_empty;
    assign busy        = (r_state != ST_IDLE);
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_ser_rx_fifo.sv
// Testbench for ser_rx_fifo: directed UART frames at BAUD_DIV=8 (128 clk/bit).
// Expected bytes go into a queue when a frame is sent; a monitor process pops
// the FIFO according to read_mode and compares each popped byte in order.
module tb_ser_rx_fifo;

    localparam int BIT = 128;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       busy;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    int         n_tests = 0;
    int         n_fail  = 0;
    // 0: no reads, 1: drain continuously, 2: pop only in a push cycle
    int         read_mode = 0;
    logic [7:0] exp_q [$];
`ifdef SER_RX_PARITY_EN
    logic       par_bad = 1'b0;
`endif

    always #5 clk = ~clk;

    ser_rx_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .rd_en       (rd_en),
        .err_clr     (err_clr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .full        (full),
        .busy        (busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .parity_err  (parity_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", name, act);
        end
    endtask

    task automatic check_flags(input string name, input logic fe, input logic oe, input logic pe);
        check({name, " frame_err"}, 32'(frame_err), 32'(fe));
        check({name, " overrun_err"}, 32'(overrun_err), 32'(oe));
        check({name, " parity_err"}, 32'(parity_err), 32'(pe));
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        $display("[TB] send 0x%02h stop=%0b", d, stop_bit);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
`ifdef SER_RX_PARITY_EN
        rx = (^d) ^ par_bad;
        wait_clk(BIT);
`endif
        rx = stop_bit;
        wait_clk(BIT);
    endtask

    task automatic pulse_err_clr;
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
    endtask

    // Monitor: decides pops at the negedge, compares the head being popped.
    initial begin
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (rd_valid && (read_mode == 1 || (read_mode == 2 && dut.w_push))) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pop: got unexpected byte %02h expected none", rd_data);
                end else begin
                    check("pop rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
                end
                rd_en = 1'b1;
            end
        end
    end

    initial begin
        logic saw_busy;
        reset   = 1'b1;
        rx      = 1'b1;
        err_clr = 1'b0;
        wait_clk(5);
        // Reset state
        check("reset rd_valid", 32'(rd_valid), 0);
        check("reset full", 32'(full), 0);
        check("reset busy", 32'(busy), 0);
        check("reset rd_data", 32'(rd_data), 0);
        check_flags("reset", 0, 0, 0);
        reset = 1'b0;
        wait_clk(20);

        // Single byte with latency window
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                wait_clk(1210);
                check("A5 not yet valid", 32'(rd_valid), 0);
                wait_clk(30);
                check("A5 valid", 32'(rd_valid), 1);
                check("A5 head", 32'(rd_data), 32'h A5);
            end
        join
        check_flags("A5", 0, 0, 0);
        read_mode = 1;
        wait_clk(5);
        check("A5 popped", 32'(rd_valid), 0);

        // Glitch rejection
        saw_busy = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        rx = 1'b1;
        check("glitch busy seen", 32'(saw_busy), 1);
        wait_clk(200);
        check("glitch busy idle", 32'(busy), 0);
        check("glitch no push", 32'(rd_valid), 0);

        // Framing error followed by a held-low break
        send_byte(8'h3C, 1'b0);
        wait_clk(40 * BIT);
        check("break frame_err", 32'(frame_err), 1);
        check("break busy in wait_hi", 32'(busy), 1);
        check("break no push", 32'(rd_valid), 0);
        rx = 1'b1;
        wait_clk(4 * BIT);
        check("release busy", 32'(busy), 0);
        pulse_err_clr();
        wait_clk(1);
        check("frame_err cleared", 32'(frame_err), 0);
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        wait_clk(20);
        check_flags("after 55", 0, 0, 0);

        // Overrun: nine frames, no reads
        read_mode = 0;
        for (int b = 1; b <= 9; b++) begin
            if (b <= 8) exp_q.push_back(8'(b));
            send_byte(8'(b), 1'b1);
            if (b == 7) check("full after 7", 32'(full), 0);
            if (b == 8) begin
                check("full after 8", 32'(full), 1);
                check("no overrun after 8", 32'(overrun_err), 0);
            end
        end
        check("overrun after 9", 32'(overrun_err), 1);
        check("still full", 32'(full), 1);
        pulse_err_clr();
        wait_clk(1);
        check("overrun cleared", 32'(overrun_err), 0);
        // Push while full with a same-cycle pop
        read_mode = 2;
        exp_q.push_back(8'h0A);
        send_byte(8'h0A, 1'b1);
        check("push+pop no overrun", 32'(overrun_err), 0);
        check("push+pop still full", 32'(full), 1);
        read_mode = 1;
        wait_clk(30);
        check("drained", 32'(rd_valid), 0);
        check("queue empty after drain", 32'(exp_q.size()), 0);

        // Reset mid-frame with a byte already buffered
        read_mode = 0;
        send_byte(8'h77, 1'b1);
        check("77 buffered", 32'(rd_valid), 1);
        rx = 1'b0;
        wait_clk(BIT);
        rx = 1'b1;
        wait_clk(4 * BIT + 64);
        check("mid-frame busy", 32'(busy), 1);
        reset = 1'b1;
        wait_clk(1);
        check("rst busy", 32'(busy), 0);
        check("rst rd_valid", 32'(rd_valid), 0);
        check("rst rd_data", 32'(rd_data), 0);
        check("rst full", 32'(full), 0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(6 * BIT);
        check("post-rst idle", 32'(busy), 0);
        check("post-rst empty", 32'(rd_valid), 0);
        read_mode = 1;
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        wait_clk(20);
        check_flags("after 12", 0, 0, 0);

`ifdef SER_RX_PARITY_EN
        // Parity: good then bad
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1);
        wait_clk(20);
        check("parity good", 32'(parity_err), 0);
        par_bad = 1'b1;
        exp_q.push_back(8'h07);
        send_byte(8'h07, 1'b1);
        par_bad = 1'b0;
        wait_clk(20);
        check("parity bad", 32'(parity_err), 1);
        pulse_err_clr();
        wait_clk(1);
        check("parity cleared", 32'(parity_err), 0);
`endif

        wait_clk(50);
        check("final queue empty", 32'(exp_q.size()), 0);
        check("final rd_valid", 32'(rd_valid), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
